lac_readout: RTL
================

LAC_READOUT -- requirements
Module: lac_readout

Interface
REQ-001 Parameter adr_width, default 11, is the sample RAM address width; depth = 2^adr_width; legal range 1..15.
REQ-002 Data width is fixed at 8 bits; the block reads from an 8-bit dual-port sample RAM through that RAM's read port.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a readout; sampled only in IDLE.
REQ-006 base_adr  in  adr_width  first RAM address to read; captured on accepted start.
REQ-007 count  in  adr_width+1  number of bytes to read, 0..depth; captured on accepted start.
REQ-008 ram_adr  out  adr_width  RAM read address; the RAM returns ram_dat one clk after ram_adr.
REQ-009 ram_dat  in  8  RAM read data.
REQ-010 tx_dat  out  8  stream byte.
REQ-011 tx_valid  out  1  tx_dat is valid.
REQ-012 tx_ready  in  1  sink accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1 on a rising edge.
REQ-013 busy  out  1  high from the cycle after an accepted start until done.
REQ-014 done  out  1  one-cycle pulse after the last byte transfers.

Function
REQ-015 The state machine SHALL have states IDLE, HDR, STREAM and DRAIN; the reset state is IDLE.
REQ-016 IDLE: an accepted start with count>0 SHALL go to STREAM (HDR if the header is compiled in); with count=0 and no header it SHALL pulse done on the next cycle and stay in IDLE.
REQ-017 Read addresses SHALL be base_adr, base_adr+1, ... and SHALL wrap modulo depth (depth-1 is followed by 0).
REQ-018 Exactly count bytes SHALL be issued; count=depth SHALL read every location once.
REQ-019 A 2-entry skid buffer SHALL absorb the 1-cycle RAM latency so that throughput is 1 byte/clk while tx_ready is held high.
REQ-020 First tx_valid SHALL assert no later than 3 clk after start in STREAM.
REQ-021 While tx_valid=1 and tx_ready=0, tx_dat and tx_valid SHALL hold stable.
REQ-022 No RAM read SHALL be issued while the skid buffer is full; the buffer SHALL never overflow or drop a byte.
REQ-023 DRAIN is entered when all reads have been issued; done SHALL pulse one cycle after the final transfer, then the state returns to IDLE.
REQ-024 start SHALL be ignored in any state other than IDLE, including on the same cycle as done.
REQ-025 tx_valid SHALL never be driven by a combinational path from tx_ready.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, ram_adr=0, tx_dat=0, tx_valid=0, busy=0, done=0, and the skid buffer to empty.
REQ-027 A reset during a readout SHALL abort it without pulsing done; the next readout SHALL start cleanly.

Configuration
REQ-028 Macro LAC_READOUT_HEADER_EN defined: HDR state emits two bytes before the data, {count zero-extended to 16}[15:8] then [7:0], under the same valid/ready rules; count=0 emits the header only, then pulses done.
REQ-029 LAC_READOUT_HEADER_EN undefined: no HDR state; the stream contains only data bytes.

Verification
REQ-030 RAM[i]=i, base=0x010, count=4, tx_ready=1 -> bytes 10,11,12,13 on consecutive cycles, then a done pulse, busy=0.
REQ-031 base=0x7FE, count=4 (adr_width=11) -> ram_adr sequence 7FE,7FF,000,001; data matches.
REQ-032 count=8, tx_ready toggling 1010... and a 5-cycle stall -> all 8 bytes arrive in order, none duplicated, and tx_dat is stable during stalls.
REQ-033 count=0 -> no tx_valid, done 1 clk after start (with header: bytes 00,00 then done).
REQ-034 reset_n pulsed low after the 3rd byte of count=10 -> outputs reach reset values at once with no done; a new start with base=0, count=2 yields bytes 00,01.
REQ-035 start re-pulsed mid-readout and on the done cycle -> ignored; the byte total equals the original count.

Source files
------------

// File: rtl/lac_readout.sv
// lac_readout: streams `count` bytes from a sample RAM read port, starting at base_adr, over valid/ready.
// Define LAC_READOUT_HEADER_EN to prepend a two-byte big-endian byte-count header to every stream.
module lac_readout #(
    parameter int adr_width = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [adr_width-1:0] base_adr,
    input  logic [adr_width:0]   count,
    output logic [adr_width-1:0] ram_adr,
    input  logic [7:0]           ram_dat,
    output logic [7:0]           tx_dat,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

`ifdef LAC_READOUT_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, STREAM, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
`endif

    state_t               state;
    state_t               state_nxt;
    logic                 done_nxt;
    logic [adr_width:0]   remaining;
    logic [7:0]           skid [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           fill;
    logic                 pend;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [7:0]           push_dat;
    logic [2:0]           level;

`ifdef LAC_READOUT_HEADER_EN
    logic                 hdr_idx;
    logic [15:0]          hdr_word;

    assign hdr_word = 16'(remaining);
`endif

    // tx_valid is a pure function of buffer occupancy, so it never depends on tx_ready.
    assign tx_valid = (fill != 2'd0);
    assign tx_dat   = skid[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign accept   = start && (state == IDLE) && !done;

    // A read is issued only if the buffer can hold its data once it returns a cycle later,
    // counting the byte already in flight (pend) and this cycle's pop.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        push     = pend;
        push_dat = ram_dat;
`ifdef LAC_READOUT_HEADER_EN
        if ((state == HDR) && (fill != 2'd2)) begin
            push     = 1'b1;
            push_dat = hdr_idx ? hdr_word[7:0] : hdr_word[15:8];
        end
`endif
        level = 3'(fill) + 3'(push) - 3'(pop);
        issue = 1'b0;
        if ((remaining != '0) && (fill != 2'd2) && (level <= 3'd1)) begin
            if (state == STREAM)
                issue = 1'b1;
`ifdef LAC_READOUT_HEADER_EN
            // Prefetch the first data byte alongside the last header byte to avoid a bubble.
            if ((state == HDR) && hdr_idx && push)
                issue = 1'b1;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef LAC_READOUT_HEADER_EN
                    state_nxt = HDR;
`else
                    if (count != '0)
                        state_nxt = STREAM;
                    else
                        done_nxt = 1'b1;
`endif
                end
            end
`ifdef LAC_READOUT_HEADER_EN
            HDR: begin
                if (push && hdr_idx) begin
                    if ((remaining == '0) || (issue && (remaining == (adr_width+1)'(1))))
                        state_nxt = DRAIN;
                    else
                        state_nxt = STREAM;
                end
            end
`endif
            STREAM: begin
                if (issue && (remaining == (adr_width+1)'(1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!pend && (fill == 2'(pop))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // NOTE: the skid storage itself is reset (not just its pointers) so tx_dat reads 0 during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_adr   <= '0;
            remaining <= '0;
            pend      <= 1'b0;
            fill      <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            skid[0]   <= 8'h00;
            skid[1]   <= 8'h00;
`ifdef LAC_READOUT_HEADER_EN
            hdr_idx   <= 1'b0;
`endif
        end else begin
            pend <= issue;
            if (accept) begin
                ram_adr   <= base_adr;
                remaining <= count;
`ifdef LAC_READOUT_HEADER_EN
                hdr_idx   <= 1'b0;
`endif
            end else if (issue) begin
                ram_adr   <= ram_adr + adr_width'(1);
                remaining <= remaining - (adr_width+1)'(1);
            end
            if (push) begin
                skid[wr_ptr] <= push_dat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fill <= fill + 2'(push) - 2'(pop);
`ifdef LAC_READOUT_HEADER_EN
            if ((state == HDR) && push)
                hdr_idx <= 1'b1;
`endif
        end
    end

endmodule
